// File: rtl/avr_pkg.sv
// Shared types and constants for the AVR bank router: bridge FSM states,
// port register indices and status bit layout.
package avr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXT_WAIT = 2'd1,
    ST_EXT_DONE = 2'd2
  } ext_state_t;

  localparam int PORT_BANK   = 0;
  localparam int PORT_STATUS = 1;
  localparam int PORT_CURX   = 2;
  localparam int PORT_CURY   = 3;

  localparam int STAT_TIMEOUT = 0;
  localparam int STAT_BUSY    = 1;

  function automatic logic [7:0] status_byte(input logic timeout_err, input logic busy);
    logic [7:0] v;
    v               = 8'h00;
    v[STAT_TIMEOUT] = timeout_err;
    v[STAT_BUSY]    = busy;
    return v;
  endfunction

endpackage

// File: rtl/avr_ext_bridge.sv
// Handshake bridge to a slow external bank: latches the access, waits for a
// one-clock ack or a timeout, then presents the read data for one clock.
module avr_ext_bridge
  import avr_pkg::*;
#(
  parameter int AW      = 20,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  input  logic          i_start,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  input  logic [7:0]    i_ext_rdata,
  input  logic          i_ext_ack,
  output ext_state_t    o_state,
  output logic          o_ext_req,
  output logic          o_ext_we,
  output logic [AW-1:0] o_ext_addr,
  output logic [7:0]    o_ext_wdata,
  output logic [7:0]    o_rdata,
  output logic          o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  ext_state_t       r_state;
  ext_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_ack;
  logic             w_expire;

  // An ack arriving on the last allowed cycle still counts as success.
  assign w_ack    = (r_state == ST_EXT_WAIT) && i_ext_ack;
  assign w_expire = (r_state == ST_EXT_WAIT) && !i_ext_ack && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (i_start) w_state_next = ST_EXT_WAIT;
      ST_EXT_WAIT: if (w_ack || w_expire) w_state_next = ST_EXT_DONE;
      ST_EXT_DONE: w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ext_req = (r_state == ST_EXT_WAIT);
    o_timeout = w_expire;
    o_state   = r_state;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt       <= '0;
      o_ext_we    <= 1'b0;
      o_ext_addr  <= '0;
      o_ext_wdata <= 8'h00;
      o_rdata     <= 8'h00;
    end else begin
      if (r_state == ST_IDLE && i_start) begin
        r_cnt       <= '0;
        o_ext_we    <= i_we;
        o_ext_addr  <= i_addr;
        o_ext_wdata <= i_wdata;
      end else if (r_state == ST_EXT_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_ack)         o_rdata <= i_ext_rdata;
      else if (w_expire) o_rdata <= 8'hFF;
    end
  end

endmodule

// File: rtl/avr_bank_router.sv
// Data-bus router for the AVR core: banked window (on-chip or external),
// exported port-register file with bank/status ports, and SRAM fallback.
module avr_bank_router
  import avr_pkg::*;
#(
  parameter int          ADDR_W     = 16,
  parameter int unsigned WIN_BASE   = 16'hF000,
  parameter int          WIN_BITS   = 12,
  parameter int          BANK_W     = 8,
  parameter int          FAST_BANKS = 2,
  parameter int          NBANKS     = 6,
  parameter int unsigned PORT_BASE  = 16'h0020,
  parameter int          NPORTS     = 16,
  parameter int          TIMEOUT    = 255
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic [ADDR_W-1:0]          i_cpu_addr,
  input  logic [7:0]                 i_cpu_din,
  output logic [7:0]                 o_cpu_dout,
  input  logic                       i_cpu_wren,
  input  logic                       i_cpu_rden,
  output logic                       o_stall,
  output logic                       o_sram_wren,
  input  logic [7:0]                 i_sram_q,
  output logic [BANK_W+WIN_BITS-1:0] o_win_addr,
  output logic                       o_win_wren,
  input  logic [7:0]                 i_win_q,
  output logic                       o_ext_req,
  output logic                       o_ext_we,
  output logic [BANK_W+WIN_BITS-1:0] o_ext_addr,
  output logic [7:0]                 o_ext_wdata,
  input  logic [7:0]                 i_ext_rdata,
  input  logic                       i_ext_ack,
  output logic [8*NPORTS-1:0]        o_port_q
);

  localparam int          XA_W     = BANK_W + WIN_BITS;
  localparam int unsigned WIN_END  = WIN_BASE + (32'd1 << WIN_BITS);
  localparam int unsigned PORT_END = PORT_BASE + 32'(NPORTS);

  logic [31:0]       w_addr32;
  logic [31:0]       w_port_off;
  logic              w_win_hit;
  logic              w_port_hit;
  logic [BANK_W-1:0] w_bank;
  logic              w_bank_fast;
  logic              w_bank_ext;
  logic              w_live;
  logic              w_port_wr;
  logic [7:0]        w_port_rd;
  logic [7:0]        w_port_val [NPORTS];
  logic              w_busy;
  logic              w_timeout;
  logic              w_ext_start;
  logic [7:0]        w_ext_rdata;
  ext_state_t        w_state;
  logic              r_timeout_err;

  // 32-bit compare so a window ending exactly at the top of the address space works.
  assign w_addr32    = 32'(i_cpu_addr);
  assign w_port_off  = w_addr32 - PORT_BASE;
  assign w_win_hit   = (w_addr32 >= WIN_BASE) && (w_addr32 < WIN_END);
  assign w_port_hit  = !w_win_hit && (w_addr32 >= PORT_BASE) && (w_addr32 < PORT_END);
  assign w_bank      = w_port_val[PORT_BANK][BANK_W-1:0];
  assign w_bank_fast = 32'(w_bank) < 32'(FAST_BANKS);
  assign w_bank_ext  = !w_bank_fast && (32'(w_bank) < 32'(NBANKS));
  assign w_busy      = (w_state != ST_IDLE);
  assign w_live      = (w_state != ST_EXT_WAIT);
  assign w_ext_start = (w_state == ST_IDLE) && w_win_hit && w_bank_ext && (i_cpu_rden || i_cpu_wren);
  assign o_stall     = w_ext_start || (w_state == ST_EXT_WAIT);
  assign o_win_addr  = {w_bank, i_cpu_addr[WIN_BITS-1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_port
      if (gi == PORT_STATUS) begin : g_status
        assign w_port_val[gi] = status_byte(r_timeout_err, w_busy);
      end else begin : g_rw
        logic [7:0] r_val;
        always_ff @(posedge i_clock or negedge i_reset_n) begin
          if (!i_reset_n)                                 r_val <= 8'h00;
          else if (w_port_wr && w_port_off == 32'(gi))    r_val <= i_cpu_din;
        end
        assign w_port_val[gi] = r_val;
      end
      assign o_port_q[gi*8 +: 8] = w_port_val[gi];
    end
  endgenerate

  always_comb begin
    w_port_rd = 8'h00;
    for (int i = 0; i < NPORTS; i++) begin
      if (w_port_off == 32'(i)) w_port_rd = w_port_val[i];
    end
  end

  // A timeout landing on the same clock as a write-1-to-clear keeps the flag set.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)
      r_timeout_err <= 1'b0;
    else if (w_timeout)
      r_timeout_err <= 1'b1;
    else if (w_port_wr && w_port_off == 32'(PORT_STATUS) && i_cpu_din[STAT_TIMEOUT])
      r_timeout_err <= 1'b0;
  end

  always_comb begin
    o_sram_wren = 1'b0;
    o_win_wren  = 1'b0;
    w_port_wr   = 1'b0;
    o_cpu_dout  = i_sram_q;
    if (w_state == ST_EXT_DONE) begin
      o_cpu_dout = w_ext_rdata;
    end else if (w_win_hit) begin
      if (w_bank_fast) begin
        o_win_wren = i_cpu_wren && w_live;
        o_cpu_dout = i_win_q;
      end else begin
        o_cpu_dout = 8'hFF;
      end
    end else if (w_port_hit) begin
      o_sram_wren = i_cpu_wren && w_live;
      w_port_wr   = i_cpu_wren && w_live;
      o_cpu_dout  = w_port_rd;
    end else begin
      o_sram_wren = i_cpu_wren && w_live;
    end
  end

  avr_ext_bridge #(
    .AW      (XA_W),
    .TIMEOUT (TIMEOUT)
  ) u_bridge (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_start     (w_ext_start),
    .i_we        (i_cpu_wren),
    .i_addr      ({w_bank, i_cpu_addr[WIN_BITS-1:0]}),
    .i_wdata     (i_cpu_din),
    .i_ext_rdata (i_ext_rdata),
    .i_ext_ack   (i_ext_ack),
    .o_state     (w_state),
    .o_ext_req   (o_ext_req),
    .o_ext_we    (o_ext_we),
    .o_ext_addr  (o_ext_addr),
    .o_ext_wdata (o_ext_wdata),
    .o_rdata     (w_ext_rdata),
    .o_timeout   (w_timeout)
  );

endmodule

// File: tb/tb_avr_bank_router.sv
// Scoreboard bench for avr_bank_router: expectations are queued when a
// transaction is driven and popped as the router's outputs are sampled.
module tb_avr_bank_router;

  localparam int TIMEOUT = 255;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [15:0]  cpu_addr = 16'h0000;
  logic [7:0]   cpu_din = 8'h00;
  logic [7:0]   cpu_dout;
  logic         cpu_wren = 1'b0;
  logic         cpu_rden = 1'b0;
  logic         stall;
  logic         sram_wren;
  logic [7:0]   sram_q = 8'h3C;
  logic [19:0]  win_addr;
  logic         win_wren;
  logic [7:0]   win_q = 8'h77;
  logic         ext_req;
  logic         ext_we;
  logic [19:0]  ext_addr;
  logic [7:0]   ext_wdata;
  logic [7:0]   ext_rdata = 8'h00;
  logic         ext_ack = 1'b0;
  logic [127:0] port_q;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string        tag;
    logic [127:0] exp;
  } sb_item_t;
  sb_item_t sb_q[$];

  always #5 clk = ~clk;

  avr_bank_router dut (
    .i_clock     (clk),
    .i_reset_n   (reset_n),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_din   (cpu_din),
    .o_cpu_dout  (cpu_dout),
    .i_cpu_wren  (cpu_wren),
    .i_cpu_rden  (cpu_rden),
    .o_stall     (stall),
    .o_sram_wren (sram_wren),
    .i_sram_q    (sram_q),
    .o_win_addr  (win_addr),
    .o_win_wren  (win_wren),
    .i_win_q     (win_q),
    .o_ext_req   (ext_req),
    .o_ext_we    (ext_we),
    .o_ext_addr  (ext_addr),
    .o_ext_wdata (ext_wdata),
    .i_ext_rdata (ext_rdata),
    .i_ext_ack   (ext_ack),
    .o_port_q    (port_q)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic sb_push(input string tag, input logic [127:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_check(input logic [127:0] obs);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 1, 0);
    end else begin
      it = sb_q.pop_front();
      check_val(it.tag, obs, it.exp);
    end
  endtask

  task automatic port_write(input logic [15:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    cpu_addr = addr; cpu_din = data; cpu_wren = 1'b1;
    sb_push($sformatf("sram_shadow_%0h", addr), 1);
    @(negedge clk);
    sb_check(sram_wren);
    @(posedge clk); #1;
    cpu_wren = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    @(posedge clk); #1;
    cpu_addr = addr; cpu_rden = 1'b1;
    sb_push(tag, exp);
    @(negedge clk);
    sb_check(cpu_dout);
    @(posedge clk); #1;
    cpu_rden = 1'b0;
  endtask

  // ack_at: EXT_WAIT cycle (1-based) on which ext_ack is pulsed; 0 = never.
  task automatic ext_access(input string tag, input logic we, input logic [15:0] addr,
                            input logic [7:0] din, input int ack_at, input logic [7:0] rdata,
                            input logic [7:0] exp_dout, input int exp_stall, input int exp_req,
                            input logic [19:0] exp_xaddr);
    int   n_stall = 0;
    int   n_req   = 0;
    int   guard   = 0;
    bit   done    = 0;
    logic [19:0] cap_addr = '0;
    logic        cap_we = 1'b0;
    logic [7:0]  cap_wdata = 8'h00;
    logic        cap_busy = 1'b0;
    sb_push({tag, "_ext_addr"}, exp_xaddr);
    sb_push({tag, "_ext_we"}, we);
    sb_push({tag, "_ext_wdata"}, din);
    sb_push({tag, "_busy"}, 1);
    sb_push({tag, "_stall_cycles"}, exp_stall);
    sb_push({tag, "_req_cycles"}, exp_req);
    sb_push({tag, "_done_dout"}, exp_dout);
    sb_push({tag, "_done_req"}, 0);
    @(posedge clk); #1;
    cpu_addr = addr; cpu_din = din;
    cpu_wren = we; cpu_rden = !we;
    while (!done && guard < TIMEOUT + 20) begin
      guard++;
      @(negedge clk);
      if (!stall) begin
        done = 1;
      end else begin
        n_stall++;
        if (ext_req) begin
          n_req++;
          if (n_req == 1) begin
            cap_addr = ext_addr; cap_we = ext_we; cap_wdata = ext_wdata; cap_busy = port_q[9];
          end
          if (n_req == ack_at) begin
            ext_ack = 1'b1; ext_rdata = rdata;
          end
        end
        @(posedge clk); #1;
        ext_ack = 1'b0;
      end
    end
    if (!done) check_val({tag, "_guard_expired"}, 1, 0);
    sb_check(cap_addr);
    sb_check(cap_we);
    sb_check(cap_wdata);
    sb_check(cap_busy);
    sb_check(n_stall);
    sb_check(n_req);
    sb_check(cpu_dout);
    sb_check(ext_req);
    @(posedge clk); #1;
    cpu_wren = 1'b0; cpu_rden = 1'b0;
  endtask

  initial begin
    #23;
    sb_push("rst_stall", 0);
    sb_push("rst_ext_req", 0);
    sb_push("rst_port_q", 0);
    sb_check(stall);
    sb_check(ext_req);
    sb_check(port_q);
    @(posedge clk); #1;
    reset_n = 1'b1;

    read_chk("bank_reset_read", 16'h0020, 8'h00);
    port_write(16'h0020, 8'h03);
    read_chk("bank_readback", 16'h0020, 8'h03);
    sb_push("port_q_bank", 8'h03);
    sb_check(port_q[7:0]);
    read_chk("sram_read", 16'h0100, 8'h3C);

    // Fast window bank 1
    port_write(16'h0020, 8'h01);
    @(posedge clk); #1;
    cpu_addr = 16'hF123; cpu_din = 8'hA5; cpu_wren = 1'b1;
    sb_push("win_wren", 1);
    sb_push("win_addr", 20'h01123);
    sb_push("win_sram_wren", 0);
    sb_push("win_stall", 0);
    @(negedge clk);
    sb_check(win_wren);
    sb_check(win_addr);
    sb_check(sram_wren);
    sb_check(stall);
    @(posedge clk); #1;
    cpu_wren = 1'b0;
    read_chk("win_read", 16'hF123, 8'h77);

    // Port 2 general register
    port_write(16'h0022, 8'h5C);
    read_chk("port2_read", 16'h0022, 8'h5C);
    sb_push("port_q_p2", 8'h5C);
    sb_check(port_q[23:16]);

    // External read with ack on the 5th wait cycle
    port_write(16'h0020, 8'h02);
    ext_access("ext_rd", 1'b0, 16'hF010, 8'h00, 5, 8'h5A, 8'h5A, 6, 5, 20'h02010);
    read_chk("status_after_ok", 16'h0021, 8'h00);

    // External write that never completes
    port_write(16'h0020, 8'h03);
    ext_access("ext_to", 1'b1, 16'hF456, 8'hC3, 0, 8'h00, 8'hFF, TIMEOUT + 1, TIMEOUT, 20'h03456);
    read_chk("status_timeout", 16'h0021, 8'h01);
    port_write(16'h0021, 8'h00);
    read_chk("status_w0_keeps", 16'h0021, 8'h01);
    port_write(16'h0021, 8'h01);
    read_chk("status_w1c", 16'h0021, 8'h00);

    // Unmapped bank
    port_write(16'h0020, 8'h20);
    read_chk("unmapped_read", 16'hF000, 8'hFF);
    @(posedge clk); #1;
    cpu_addr = 16'hF000; cpu_din = 8'h11; cpu_wren = 1'b1;
    sb_push("unm_win_wren", 0);
    sb_push("unm_sram_wren", 0);
    sb_push("unm_stall", 0);
    sb_push("unm_ext_req", 0);
    @(negedge clk);
    sb_check(win_wren);
    sb_check(sram_wren);
    sb_check(stall);
    @(posedge clk); #1;
    sb_check(ext_req);
    cpu_wren = 1'b0;

    // Reset in the middle of an external wait
    port_write(16'h0020, 8'h02);
    @(posedge clk); #1;
    cpu_addr = 16'hF010; cpu_rden = 1'b1;
    repeat (4) @(negedge clk);
    sb_push("pre_rst_ext_req", 1);
    sb_check(ext_req);
    #2;
    reset_n = 1'b0;
    #1;
    sb_push("midrst_ext_req", 0);
    sb_push("midrst_stall", 0);
    sb_push("midrst_bank", 8'h00);
    sb_check(ext_req);
    sb_check(stall);
    sb_check(port_q[7:0]);
    cpu_rden = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    ext_ack = 1'b1; ext_rdata = 8'h5A;
    @(posedge clk); #1;
    ext_ack = 1'b0;
    sb_push("late_ack_req", 0);
    sb_push("late_ack_stall", 0);
    sb_push("late_ack_status", 8'h00);
    @(negedge clk);
    sb_check(ext_req);
    sb_check(stall);
    sb_check(port_q[15:8]);

    if (sb_q.size() != 0) check_val("sb_leftover", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/avr_bank_router.md
Name: avr_bank_router

Overview:
- Parametrised memory/port router between the AVR core data bus and the on-chip memories.
- Successor of the fixed single-window top-level router.
- Adds: N banks behind a configurable window, a generic exported port-register file, a status port, and a stall/ack handshake to slow external banks (e.g. SDRAM) with timeout.
- Sits between avrcpu data bus and memsram / window memories / external bank controller.

Parameters:
ADDR_W, 16, CPU data address width
WIN_BASE, 16'hF000, first address of banked window
WIN_BITS, 12, window size = 2**WIN_BITS bytes
BANK_W, 8, bank register width
FAST_BANKS, 2, banks 0..FAST_BANKS-1 map to on-chip window memory
NBANKS, 6, banks FAST_BANKS..NBANKS-1 map to external port; bank >= NBANKS unmapped
PORT_BASE, 16'h0020, address of port register 0
NPORTS, 16, port register count (>=3)
TIMEOUT, 255, external ack timeout in clocks

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
cpu_addr  in  ADDR_W  CPU data address
cpu_din  in  8  write data from CPU
cpu_dout  out  8  read data to CPU (combinational except EXT_DONE)
cpu_wren  in  1  write strobe
cpu_rden  in  1  read strobe
stall  out  1  CPU hold request
sram_wren  out  1  SRAM write enable
sram_q  in  8  SRAM read data
win_addr  out  BANK_W+WIN_BITS  {bank, cpu_addr[WIN_BITS-1:0]}
win_wren  out  1  fast window write enable
win_q  in  8  fast window read data
ext_req  out  1  external access request
ext_we  out  1  external write
ext_addr  out  BANK_W+WIN_BITS  latched {bank, offset}
ext_wdata  out  8  latched write data
ext_rdata  in  8  external read data
ext_ack  in  1  external completion, one clock
port_q  out  8*NPORTS  flattened port registers (cursor_x, cursor_y etc. for vga)

Behaviour:
- Reset: all port regs 0 (bank=0, status=0), FSM IDLE, ext_req=0, stall=0, latches 0.
- Decode priority:
  - window hit: WIN_BASE <= addr < WIN_BASE+2**WIN_BITS
  - else port hit: PORT_BASE <= addr < PORT_BASE+NPORTS
  - else SRAM
- Window hit, bank < FAST_BANKS: win_wren=cpu_wren, sram_wren=0, cpu_dout=win_q.
- Window hit, bank >= NBANKS: writes dropped, cpu_dout=8'hFF, no stall.
- Port hit:
  - cpu_dout = port reg.
  - sram_wren=cpu_wren: SRAM shadows ports.
  - Write lands on rising clock.
  - Port 0 = bank.
  - Port 1 = status: bit0 timeout_err (write-1-to-clear), bit1 ext_busy (read-only); other bits read 0.
  - Ports 2..NPORTS-1 general R/W.
- SRAM: sram_wren=cpu_wren, cpu_dout=sram_q.
- External bank (FAST_BANKS <= bank < NBANKS), FSM IDLE/EXT_WAIT/EXT_DONE:
  - IDLE + (rden|wren) + ext hit:
    - stall=1 combinationally same cycle.
    - On clock: latch ext_addr/ext_wdata/ext_we, go to EXT_WAIT, counter=0.
  - EXT_WAIT:
    - ext_req=1, stall=1, inputs ignored.
    - ext_ack: latch ext_rdata, go to EXT_DONE.
    - Counter reaches TIMEOUT without ack: latch 8'hFF, set timeout_err, go to EXT_DONE, drop req.
  - EXT_DONE:
    - stall=0, cpu_dout=latched data for one clock, then IDLE.
    - Same access is not re-issued.
  - ext_ack outside EXT_WAIT is ignored.
  - ext_busy = (state != IDLE).
- Simultaneous timeout set and W1C clear of bit0: set wins.
- reset_n low mid-transaction: ext_req and stall drop immediately (async); no ack expected.
- Bank written at an address whose low bits fall in the window: not possible, since the window has priority; bank lives only at PORT_BASE.
- Counter width = clog2(TIMEOUT+1).

Decomposition:
- Shared package avr_pkg: FSM state enum (ST_IDLE, ST_EXT_WAIT, ST_EXT_DONE), port index constants (PORT_BANK=0, PORT_STATUS=1, PORT_CURX, PORT_CURY), status bit positions.
- One sub-module: avr_ext_bridge (FSM, latches, timeout counter); decode and port file stay in the top.

Test Plan:
- Reset, then read 0x0020 -> 0x00; write 0x03 to 0x0020, read back -> 0x03; port_q[7:0]=0x03.
- Bank=1, write 0xA5 to 0xF123 -> win_wren=1, win_addr={8'h01,12'h123}, sram_wren=0; read returns win_q.
- Bank=2, read 0xF010, ext_ack after 5 clocks with ext_rdata=0x5A -> stall high 6 clocks, ext_req high 5, EXT_DONE cpu_dout=0x5A, ext_addr={8'h02,12'h010}.
- Bank=3, write with no ack -> ext_req drops after TIMEOUT clocks, status=0x01; write 0x01 to 0x0021 -> status=0x00.
- Bank=0x20 (unmapped), read 0xF000 -> 0xFF, stall=0; write -> no enable asserted.
- reset_n asserted during EXT_WAIT -> ext_req=0, stall=0, bank=0 at once; late ext_ack ignored.
